// File: rtl/bp_fe_queue_buffer.sv
// rtl/bp_fe_queue_buffer.sv - checkpointing FIFO between FE queue and BE issue
// Speculative read pointer plus commit pointer allow replay (roll) and flush (clr).
module bp_fe_queue_buffer #(
  parameter int els_p         = 8,
  parameter int entry_width_p = 96,
  localparam int ptr_width_lp = $clog2(els_p) + 1
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,

  input  logic [entry_width_p-1:0] fe_queue_i,
  input  logic                     fe_queue_v_i,
  output logic                     fe_queue_ready_o,

  output logic [entry_width_p-1:0] fe_queue_o,
  output logic                     fe_queue_v_o,
  input  logic                     fe_queue_yumi_i,

  input  logic                     deq_v_i,
  input  logic                     roll_v_i,
  input  logic                     clr_v_i,

  output logic                     empty_o,
  output logic [ptr_width_lp-1:0]  count_o
);

  localparam int idx_width_lp = ptr_width_lp - 1;
  localparam logic [ptr_width_lp-1:0] ptr_one_lp = ptr_width_lp'(1);

  logic [entry_width_p-1:0] mem [els_p];

  logic [ptr_width_lp-1:0] wptr_r, rptr_r, cptr_r;
  logic [ptr_width_lp-1:0] wptr_n, rptr_n, cptr_n;
  logic                    we;
  logic                    full;

  // Flags come only from registered pointers so ready never depends on inputs.
  assign full = (wptr_r[ptr_width_lp-1] != cptr_r[ptr_width_lp-1])
              & (wptr_r[idx_width_lp-1:0] == cptr_r[idx_width_lp-1:0]);

  assign fe_queue_ready_o = ~full;
  assign fe_queue_v_o     = (rptr_r != wptr_r);
  assign fe_queue_o       = mem[rptr_r[idx_width_lp-1:0]];
  assign empty_o          = (wptr_r == cptr_r);
  assign count_o          = wptr_r - cptr_r;

  always_comb begin
    wptr_n = wptr_r;
    rptr_n = rptr_r;
    cptr_n = cptr_r;
    we     = 1'b0;
    if (clr_v_i) begin
      wptr_n = '0;
      rptr_n = '0;
      cptr_n = '0;
    end else begin
      if (fe_queue_v_i) begin
        we     = 1'b1;
        wptr_n = wptr_r + ptr_one_lp;
      end
      if (deq_v_i)
        cptr_n = cptr_r + ptr_one_lp;
      // Roll rewinds to the post-commit pointer, so a same-cycle deq is honoured.
      if (roll_v_i)
        rptr_n = cptr_n;
      else if (fe_queue_yumi_i)
        rptr_n = rptr_r + ptr_one_lp;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wptr_r <= '0;
      rptr_r <= '0;
      cptr_r <= '0;
    end else begin
      wptr_r <= wptr_n;
      rptr_r <= rptr_n;
      cptr_r <= cptr_n;
    end
  end

  always_ff @(posedge clk_i) begin
    if (we)
      mem[wptr_r[idx_width_lp-1:0]] <= fe_queue_i;
  end

`ifndef SYNTHESIS
  a_enq_when_full: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    !(fe_queue_v_i && !fe_queue_ready_o))
    else $error("enqueue while not ready");
  a_yumi_when_empty: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    !(fe_queue_yumi_i && !fe_queue_v_o))
    else $error("yumi without valid entry");
  a_deq_unissued: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    !(deq_v_i && (cptr_r == rptr_r) && !clr_v_i))
    else $error("commit of unissued entry");
  a_els_pow2: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    (els_p >= 2) && ((els_p & (els_p - 1)) == 0))
    else $error("els_p must be a power of two >= 2");
`endif

endmodule

// File: tb/tb_bp_fe_queue_buffer.sv
// tb/tb_bp_fe_queue_buffer.sv - randomized bench with queue-based reference model
module tb_bp_fe_queue_buffer;
  localparam int ELS = 8;
  localparam int W   = 96;
  localparam int PW  = $clog2(ELS) + 1;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [W-1:0]  fe_queue_i;
  logic          fe_queue_v_i, fe_queue_ready_o;
  logic [W-1:0]  fe_queue_o;
  logic          fe_queue_v_o, fe_queue_yumi_i;
  logic          deq_v_i, roll_v_i, clr_v_i;
  logic          empty_o;
  logic [PW-1:0] count_o;

  always #5 clk = ~clk;

  bp_fe_queue_buffer #(.els_p(ELS), .entry_width_p(W)) dut (
    .clk_i(clk), .reset_n_i(reset_n),
    .fe_queue_i(fe_queue_i), .fe_queue_v_i(fe_queue_v_i), .fe_queue_ready_o(fe_queue_ready_o),
    .fe_queue_o(fe_queue_o), .fe_queue_v_o(fe_queue_v_o), .fe_queue_yumi_i(fe_queue_yumi_i),
    .deq_v_i(deq_v_i), .roll_v_i(roll_v_i), .clr_v_i(clr_v_i),
    .empty_o(empty_o), .count_o(count_o)
  );

  int total = 0;
  int bad   = 0;

  // Reference: entries held oldest-first, and how many of them have been issued.
  logic [W-1:0] held[$];
  int           issued = 0;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outs();
    chk("count", W'(count_o), W'(held.size()));
    chk("empty", W'(empty_o), W'(held.size() == 0));
    chk("ready", W'(fe_queue_ready_o), W'(held.size() < ELS));
    chk("v_o", W'(fe_queue_v_o), W'(issued < held.size()));
    if (issued < held.size())
      chk("data", fe_queue_o, held[issued]);
  endtask

  task automatic cyc(input bit enq, input logic [W-1:0] d, input bit yumi,
                     input bit deq, input bit roll, input bit clr);
    @(negedge clk);
    check_outs();
    fe_queue_v_i    = enq;
    fe_queue_i      = d;
    fe_queue_yumi_i = yumi;
    deq_v_i         = deq;
    roll_v_i        = roll;
    clr_v_i         = clr;
    @(posedge clk);
    #1;
    if (clr) begin
      held.delete();
      issued = 0;
    end else begin
      if (deq) begin
        void'(held.pop_front());
        issued--;
      end
      if (roll)      issued = 0;
      else if (yumi) issued++;
      if (enq)       held.push_back(d);
    end
    fe_queue_v_i = 0; fe_queue_yumi_i = 0; deq_v_i = 0; roll_v_i = 0; clr_v_i = 0;
  endtask

  function automatic logic [W-1:0] rnd();
    return {$urandom(), $urandom(), $urandom()};
  endfunction

  logic [W-1:0] d[10];

  initial begin
    reset_n = 1'b0;
    fe_queue_i = '0; fe_queue_v_i = 0; fe_queue_yumi_i = 0;
    deq_v_i = 0; roll_v_i = 0; clr_v_i = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    foreach (d[i]) d[i] = rnd();

    // Enqueue A,B,C; read them back, then commit all three.
    for (int i = 0; i < 3; i++) cyc(1, d[i], 0, 0, 0, 0);
    chk("abc_count", W'(count_o), W'(3));
    for (int i = 0; i < 3; i++) cyc(0, '0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, '0, 0, 1, 0, 0);
    chk("abc_empty", W'(empty_o), W'(1));
    chk("abc_count0", W'(count_o), W'(0));

    // Fill to full, free one slot, wrap a 9th entry.
    for (int i = 0; i < 8; i++) cyc(1, d[i], 0, 0, 0, 0);
    chk("full_ready", W'(fe_queue_ready_o), W'(0));
    chk("full_count", W'(count_o), W'(8));
    cyc(0, '0, 1, 0, 0, 0);
    cyc(0, '0, 0, 1, 0, 0);
    chk("space_ready", W'(fe_queue_ready_o), W'(1));
    cyc(1, d[8], 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) cyc(0, '0, 1, 0, 0, 0);
    cyc(0, '0, 0, 0, 0, 1);

    // Enqueue 4, yumi 3, deq 1, roll: replay from entry #2.
    for (int i = 0; i < 4; i++) cyc(1, d[i], 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, '0, 1, 0, 0, 0);
    cyc(0, '0, 0, 1, 0, 0);
    cyc(0, '0, 0, 0, 1, 0);
    chk("roll_data", fe_queue_o, d[1]);
    chk("roll_count", W'(count_o), W'(3));
    for (int i = 0; i < 3; i++) cyc(0, '0, 1, 0, 0, 0);
    cyc(0, '0, 0, 0, 0, 1);

    // Roll and deq together with rptr=3, cptr=1.
    for (int i = 0; i < 3; i++) cyc(1, d[i], 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, '0, 1, 0, 0, 0);
    cyc(0, '0, 0, 1, 0, 0);
    cyc(0, '0, 0, 1, 1, 0);
    chk("rolldeq_count", W'(count_o), W'(1));
    chk("rolldeq_data", fe_queue_o, d[2]);
    chk("rolldeq_v", W'(fe_queue_v_o), W'(1));

    // Clear with simultaneous enqueue and yumi while holding 5.
    cyc(0, '0, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) cyc(1, d[i], 0, 0, 0, 0);
    cyc(1, d[9], 1, 0, 0, 1);
    chk("clr_count", W'(count_o), W'(0));
    chk("clr_empty", W'(empty_o), W'(1));
    chk("clr_v", W'(fe_queue_v_o), W'(0));
    chk("clr_ready", W'(fe_queue_ready_o), W'(1));

    // Asynchronous reset between edges while 6 entries are held.
    for (int i = 0; i < 6; i++) cyc(1, d[i], 0, 0, 0, 0);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_count", W'(count_o), W'(0));
    chk("arst_empty", W'(empty_o), W'(1));
    chk("arst_v", W'(fe_queue_v_o), W'(0));
    chk("arst_ready", W'(fe_queue_ready_o), W'(1));
    held.delete();
    issued = 0;
    @(negedge clk);
    reset_n = 1'b1;
    cyc(1, d[7], 0, 0, 0, 0);
    chk("arst_first", fe_queue_o, d[7]);
    cyc(0, '0, 1, 0, 0, 0);

    // Randomized legal traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      bit enq, yumi, deq, roll, clr;
      clr  = ($urandom_range(0, 49) == 0);
      roll = ($urandom_range(0, 11) == 0);
      enq  = (held.size() < ELS) && ($urandom_range(0, 2) != 0);
      yumi = (issued < held.size()) && ($urandom_range(0, 2) != 0);
      deq  = (issued > 0) && ($urandom_range(0, 2) == 0);
      cyc(enq, rnd(), yumi, deq, roll, clr);
    end
    @(negedge clk);
    check_outs();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
